// File: rtl/id_ex_forward_stage_pkg.sv
// rtl/id_ex_forward_stage_pkg.sv - shared forward-select encoding for the hazard controller and ID/EX stage
package id_ex_forward_stage_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int CTRL_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    FWD_NULL = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  function automatic logic fwd_is_bypass(input logic [1:0] sel);
    return fwd_sel_e'(sel) != FWD_NULL;
  endfunction

endpackage

// File: rtl/id_ex_forward_stage_if.sv
// rtl/id_ex_forward_stage_if.sv - ID-side inputs, bypass/hazard controls and EX-side outputs of the ID/EX stage
interface id_ex_forward_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [4:0]        id_rs1_addr;
  logic [4:0]        id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic              id_alu_src_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_write_enable;
  logic [4:0]        id_reg_write_addr;
  logic [1:0]        forward_1;
  logic [1:0]        forward_2;
  logic [XLEN-1:0]   ex_fwd_data;
  logic [XLEN-1:0]   mem_fwd_data;
  logic [XLEN-1:0]   wb_fwd_data;
  logic              bubble;
  logic              flush;
  logic              hold;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_op1;
  logic [XLEN-1:0]   ex_op2;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_write_enable;
  logic [4:0]        ex_reg_write_addr;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_alu_src_imm, id_ctrl, id_reg_write_enable, id_reg_write_addr,
           forward_1, forward_2, ex_fwd_data, mem_fwd_data, wb_fwd_data,
           bubble, flush, hold,
    input  ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs2_data, ex_ctrl,
           ex_reg_write_enable, ex_reg_write_addr
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_alu_src_imm, id_ctrl, id_reg_write_enable, id_reg_write_addr,
           forward_1, forward_2, ex_fwd_data, mem_fwd_data, wb_fwd_data,
           bubble, flush, hold,
    output ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs2_data, ex_ctrl,
           ex_reg_write_enable, ex_reg_write_addr
  );
endinterface

// File: rtl/id_ex_forward_stage_operand_bypass_mux.sv
// rtl/id_ex_forward_stage_operand_bypass_mux.sv - selects one source operand from regfile or a bypass stage
module operand_bypass_mux
  import id_ex_forward_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  input  logic [1:0]      fwd_sel,
  input  logic [4:0]      rs_addr,
  output logic [XLEN-1:0] operand
);

  // x0 reads zero even if a stale hazard match points at a bypass stage
  always_comb begin
    operand = rf_data;
    if (rs_addr == 5'd0) begin
      operand = '0;
    end else begin
      case (fwd_sel_e'(fwd_sel))
        FWD_EX:  operand = ex_data;
        FWD_MEM: operand = mem_data;
        FWD_WB:  operand = wb_data;
        default: operand = rf_data;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// rtl/id_ex_forward_stage.sv - ID/EX register with operand bypass; optional counters under ID_EX_PERF_CNT_EN
module id_ex_forward_stage
  import id_ex_forward_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  id_ex_forward_stage_if.slave io
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]          perf_bubbles,
  output logic [31:0]          perf_flushes,
  output logic [31:0]          perf_fwd_uses
`endif
);

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] op2;

  operand_bypass_mux #(.XLEN(XLEN)) u_mux_rs1 (
    .rf_data  (io.id_rs1_data),
    .ex_data  (io.ex_fwd_data),
    .mem_data (io.mem_fwd_data),
    .wb_data  (io.wb_fwd_data),
    .fwd_sel  (io.forward_1),
    .rs_addr  (io.id_rs1_addr),
    .operand  (src1)
  );

  operand_bypass_mux #(.XLEN(XLEN)) u_mux_rs2 (
    .rf_data  (io.id_rs2_data),
    .ex_data  (io.ex_fwd_data),
    .mem_data (io.mem_fwd_data),
    .wb_data  (io.wb_fwd_data),
    .fwd_sel  (io.forward_2),
    .rs_addr  (io.id_rs2_addr),
    .operand  (src2)
  );

  assign op2 = io.id_alu_src_imm ? io.id_imm : src2;

  // flush beats hold so a killed slot never survives a stall; hold beats bubble
  logic kill_slot;
  logic capture;
  assign kill_slot = io.flush | (io.bubble & ~io.hold);
  assign capture   = ~io.flush & ~io.hold & ~io.bubble;

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [XLEN-1:0]   ex_op1_q;
  logic [XLEN-1:0]   ex_op2_q;
  logic [XLEN-1:0]   ex_rs2_data_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic              ex_we_q;
  logic [4:0]        ex_wa_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_rs2_data_q <= '0;
      ex_ctrl_q     <= '0;
      ex_we_q       <= 1'b0;
      ex_wa_q       <= '0;
    end else if (kill_slot) begin
      ex_valid_q <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (capture) begin
      ex_valid_q    <= io.id_valid;
      ex_pc_q       <= io.id_pc;
      ex_imm_q      <= io.id_imm;
      ex_op1_q      <= src1;
      ex_op2_q      <= op2;
      ex_rs2_data_q <= src2;
      ex_ctrl_q     <= io.id_ctrl;
      ex_we_q       <= io.id_reg_write_enable & io.id_valid;
      ex_wa_q       <= io.id_reg_write_addr;
    end
  end

  assign io.ex_valid            = ex_valid_q;
  assign io.ex_pc               = ex_pc_q;
  assign io.ex_imm              = ex_imm_q;
  assign io.ex_op1              = ex_op1_q;
  assign io.ex_op2              = ex_op2_q;
  assign io.ex_rs2_data         = ex_rs2_data_q;
  assign io.ex_ctrl             = ex_ctrl_q;
  assign io.ex_reg_write_enable = ex_we_q;
  assign io.ex_reg_write_addr   = ex_wa_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] fwd_inc;
  assign fwd_inc = 32'(fwd_is_bypass(io.forward_1)) + 32'(fwd_is_bypass(io.forward_2));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles  <= '0;
      perf_flushes  <= '0;
      perf_fwd_uses <= '0;
    end else begin
      if (io.bubble && !io.flush && !io.hold) perf_bubbles <= perf_bubbles + 32'd1;
      if (io.flush) perf_flushes <= perf_flushes + 32'd1;
      if (capture && io.id_valid) perf_fwd_uses <= perf_fwd_uses + fwd_inc;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb/tb_id_ex_forward_stage.sv - directed bench with reference model for id_ex_forward_stage
module tb_id_ex_forward_stage;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_ex_forward_stage_if #(.XLEN(32), .CTRL_W(16)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles, perf_flushes, perf_fwd_uses;
`endif

  id_ex_forward_stage #(.XLEN(32), .CTRL_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .perf_bubbles  (perf_bubbles),
    .perf_flushes  (perf_flushes),
    .perf_fwd_uses (perf_fwd_uses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: what EX must hold after each edge
  bit          model_ok;
  logic        e_valid, e_we;
  logic [31:0] e_pc, e_imm, e_op1, e_op2, e_rs2;
  logic [15:0] e_ctrl;
  logic [4:0]  e_wa;

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [1:0] code,
      input logic [31:0] rf, input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb);
    logic [31:0] cand [4];
    cand[0] = rf; cand[1] = ex; cand[2] = mem; cand[3] = wb;
    return (a == 5'd0) ? 32'd0 : cand[code];
  endfunction

  always @(posedge clk) begin
    logic [31:0] s1, s2;
    s1 = resolve(bus.id_rs1_addr, bus.forward_1, bus.id_rs1_data, bus.ex_fwd_data, bus.mem_fwd_data, bus.wb_fwd_data);
    s2 = resolve(bus.id_rs2_addr, bus.forward_2, bus.id_rs2_data, bus.ex_fwd_data, bus.mem_fwd_data, bus.wb_fwd_data);
    if (rst) begin
      e_valid = 0; e_we = 0; e_ctrl = 0; e_wa = 0;
      e_pc = 0; e_imm = 0; e_op1 = 0; e_op2 = 0; e_rs2 = 0;
    end else if (bus.flush || (bus.bubble && !bus.hold)) begin
      e_valid = 0; e_we = 0; e_ctrl = 0;
    end else if (!bus.hold) begin
      e_valid = bus.id_valid;
      e_we    = bus.id_valid && bus.id_reg_write_enable;
      e_ctrl  = bus.id_ctrl;
      e_wa    = bus.id_reg_write_addr;
      e_pc    = bus.id_pc;
      e_imm   = bus.id_imm;
      e_op1   = s1;
      e_op2   = bus.id_alu_src_imm ? bus.id_imm : s2;
      e_rs2   = s2;
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_valid", 32'(bus.ex_valid), 32'(e_valid));
      chk("m_we",    32'(bus.ex_reg_write_enable), 32'(e_we));
      chk("m_ctrl",  32'(bus.ex_ctrl), 32'(e_ctrl));
      if (e_valid) begin
        chk("m_wa",  32'(bus.ex_reg_write_addr), 32'(e_wa));
        chk("m_pc",  bus.ex_pc, e_pc);
        chk("m_imm", bus.ex_imm, e_imm);
        chk("m_op1", bus.ex_op1, e_op1);
        chk("m_op2", bus.ex_op2, e_op2);
        chk("m_rs2", bus.ex_rs2_data, e_rs2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; model_ok = 0;
    rst = 1'b1;
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_imm = 0;
    bus.id_rs1_addr = 5; bus.id_rs2_addr = 6;
    bus.id_rs1_data = 32'h99; bus.id_rs2_data = 32'h77;
    bus.id_alu_src_imm = 0; bus.id_ctrl = 16'h1234;
    bus.id_reg_write_enable = 1; bus.id_reg_write_addr = 3;
    bus.forward_1 = 0; bus.forward_2 = 0;
    bus.ex_fwd_data = 32'h11; bus.mem_fwd_data = 32'h22; bus.wb_fwd_data = 32'h33;
    bus.bubble = 0; bus.flush = 0; bus.hold = 0;
    tick(); tick();
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_we",    32'(bus.ex_reg_write_enable), 0);
    chk("rst_ctrl",  32'(bus.ex_ctrl), 0);
    chk("rst_op1",   bus.ex_op1, 0);

    rst = 0;
    bus.forward_1 = 1; tick(); chk("fwd_ex",  bus.ex_op1, 32'h11);
    bus.forward_1 = 2; tick(); chk("fwd_mem", bus.ex_op1, 32'h22);
    bus.forward_1 = 3; tick(); chk("fwd_wb",  bus.ex_op1, 32'h33);
    bus.forward_1 = 0; tick(); chk("fwd_rf",  bus.ex_op1, 32'h99);

    bus.id_rs1_addr = 0; bus.forward_1 = 1; bus.ex_fwd_data = 32'hFFFF_FFFF;
    tick(); chk("x0_op1", bus.ex_op1, 0);
    bus.id_rs1_addr = 5; bus.ex_fwd_data = 32'h11;

    bus.id_alu_src_imm = 1; bus.id_imm = 32'hFFFF_FFF0; bus.forward_2 = 2; bus.mem_fwd_data = 32'h44;
    tick();
    chk("imm_op2", bus.ex_op2, 32'hFFFF_FFF0);
    chk("imm_rs2", bus.ex_rs2_data, 32'h44);
    bus.id_alu_src_imm = 0; bus.id_imm = 0; bus.forward_2 = 0; bus.mem_fwd_data = 32'h22;

    bus.forward_1 = 1; bus.id_reg_write_addr = 7; bus.bubble = 1;
    tick();
    chk("bub_valid", 32'(bus.ex_valid), 0);
    chk("bub_we",    32'(bus.ex_reg_write_enable), 0);
    bus.bubble = 0;
    tick();
    chk("rel_valid", 32'(bus.ex_valid), 1);
    chk("rel_wa",    32'(bus.ex_reg_write_addr), 7);
    chk("rel_we",    32'(bus.ex_reg_write_enable), 1);

    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc = 32'h200 + 32'(i) * 4; bus.id_rs1_data = 32'hA0 + 32'(i);
      bus.forward_1 = 2'(i); bus.id_reg_write_addr = 5'(9 + i); bus.bubble = (i == 1);
      tick();
      chk("hold_valid", 32'(bus.ex_valid), 1);
      chk("hold_pc",    bus.ex_pc, 32'h100);
      chk("hold_op1",   bus.ex_op1, 32'h11);
      chk("hold_wa",    32'(bus.ex_reg_write_addr), 7);
    end
    bus.bubble = 0; bus.flush = 1;
    tick();
    chk("hfl_valid", 32'(bus.ex_valid), 0);
    chk("hfl_we",    32'(bus.ex_reg_write_enable), 0);
    bus.hold = 0; bus.flush = 0;

    tick();
    bus.flush = 1; tick();
    chk("fl_valid", 32'(bus.ex_valid), 0);
    chk("fl_ctrl",  32'(bus.ex_ctrl), 0);
    bus.flush = 0;

    bus.id_valid = 0; bus.forward_1 = 3; bus.forward_2 = 3;
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 0);
    chk("inv_we",    32'(bus.ex_reg_write_enable), 0);
    bus.id_valid = 1;

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        bus.forward_1 = 2'(a); bus.forward_2 = 2'(b);
        bus.id_pc = 32'h400 + 32'(a * 16 + b * 4);
        bus.id_rs2_addr = (b == 3) ? 5'd0 : 5'd6;
        tick();
      end
    end
    bus.id_rs2_addr = 6;

    chk("pre_rst_valid", 32'(bus.ex_valid), 1);
    rst = 1; tick();
    chk("mrst_valid", 32'(bus.ex_valid), 0);
    chk("mrst_we",    32'(bus.ex_reg_write_enable), 0);
    chk("mrst_pc",    bus.ex_pc, 0);
    chk("mrst_op2",   bus.ex_op2, 0);
    rst = 0;

`ifdef ID_EX_PERF_CNT_EN
    bus.forward_1 = 0; bus.forward_2 = 0;
    bus.bubble = 1; repeat (5) tick();
    bus.bubble = 0; bus.flush = 1; repeat (2) tick();
    bus.flush = 0; bus.forward_1 = 1; bus.forward_2 = 2; repeat (3) tick();
    chk("perf_bubbles",  perf_bubbles, 5);
    chk("perf_flushes",  perf_flushes, 2);
    chk("perf_fwd_uses", perf_fwd_uses, 6);
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
